// File: rtl/fetch_pkg.sv
// Shared definitions for the 6502 fetch stage.
//   fetch_state_t        : FSM state encoding; debug_state exposes it directly
//   DEFAULT_RESET_VECTOR : address of the reset vector low byte
//   opcode_length()      : instruction length 1..3 from the opcode byte.
//                          Execute calls the same function.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_VEC_LO  = 3'd0,
    ST_VEC_HI  = 3'd1,
    ST_OPCODE  = 3'd2,
    ST_OPER_LO = 3'd3,
    ST_OPER_HI = 3'd4,
    ST_HOLD    = 3'd5
  } fetch_state_t;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;

  // The first matching rule wins. Illegal opcodes still follow these rules,
  // so the fetch stage never traps.
  function automatic logic [1:0] opcode_length(input logic [7:0] opcode);
    logic [3:0] lo;
    lo = opcode[3:0];
    if (opcode == 8'h20 || lo >= 4'hC ||
        ((lo == 4'h9 || lo == 4'hB) && opcode[4]))
      return 2'd3;
    if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60 ||
        lo == 4'h8 || lo == 4'hA)
      return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// Read-latency pacing counter for the fetch stage.
//   clk, resetn : clock and asynchronous active-low reset
//   clear       : restart the count (a new address was launched out of order)
//   enable      : a byte read is outstanding
//   strobe      : read_data is valid for the address launched READ_LATENCY+1
//                 edges earlier
// The count returns to zero on every strobe, so the byte launched on that
// same edge starts timing immediately.
module fetch_wait_ctr #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  logic [1:0] cnt;

  assign strobe = enable && (cnt == 2'(READ_LATENCY));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 2'd0;
    end else if (clear || strobe) begin
      cnt <= 2'd0;
    end else if (enable) begin
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the 6502 core. After reset it reads the vector at
// RESET_VECTOR/RESET_VECTOR+1, then repeatedly reads an opcode plus 0..2
// operand bytes and offers the whole instruction to execute.
//   clk, resetn        : clock, asynchronous active-low reset
//   address            : registered memory read address
//   read_data          : memory read data, READ_LATENCY cycles after sampling
//   redirect_valid/pc  : one-cycle restart request from execute
//   instr_*            : instruction bundle, valid/ready handshake
//   debug_state        : current FSM state encoding
//
// Handshake: the bundle transfers on a rising edge where instr_valid and
// instr_ready are both 1. While instr_valid=1 and instr_ready=0 every instr_*
// output holds. A redirect in any post-vector state overrides the handshake.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] address,
  input  logic [7:0]  read_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [15:0] instr_operand,
  output logic [1:0]  instr_length,
  output logic [15:0] instr_pc,
  output logic [2:0]  debug_state
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc;
  logic         strobe;
  logic         redirect_take;
  logic         accept;
  logic [1:0]   new_length;
  logic [15:0]  next_pc;

  // Redirects are only meaningful once a program counter exists.
  assign redirect_take = redirect_valid &&
                         (state_q != ST_VEC_LO) && (state_q != ST_VEC_HI);
  assign accept        = (state_q == ST_HOLD) && instr_ready;
  assign new_length    = opcode_length(read_data);
  assign next_pc       = instr_pc + {14'd0, instr_length};

  assign instr_valid = (state_q == ST_HOLD);
  assign debug_state = state_q;

  fetch_wait_ctr #(.READ_LATENCY(READ_LATENCY)) u_wait_ctr (
    .clk    (clk),
    .resetn (resetn),
    .clear  (redirect_take),
    .enable (state_q != ST_HOLD),
    .strobe (strobe)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_VEC_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_take) begin
      state_d = ST_OPCODE;
    end else begin
      case (state_q)
        ST_VEC_LO:  if (strobe) state_d = ST_VEC_HI;
        ST_VEC_HI:  if (strobe) state_d = ST_OPCODE;
        ST_OPCODE:  if (strobe) state_d = (new_length == 2'd1) ? ST_HOLD : ST_OPER_LO;
        ST_OPER_LO: if (strobe) state_d = (instr_length == 2'd3) ? ST_OPER_HI : ST_HOLD;
        ST_OPER_HI: if (strobe) state_d = ST_HOLD;
        ST_HOLD:    if (accept) state_d = ST_OPCODE;
        default:    state_d = ST_VEC_LO;
      endcase
    end
  end

  // Datapath. pc[7:0] doubles as the vector low-byte holding register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      address       <= RESET_VECTOR;
      pc            <= 16'd0;
      instr_opcode  <= 8'd0;
      instr_operand <= 16'd0;
      instr_length  <= 2'd0;
      instr_pc      <= 16'd0;
    end else if (redirect_take) begin
      address <= redirect_pc;
      pc      <= redirect_pc;
    end else begin
      case (state_q)
        ST_VEC_LO: if (strobe) begin
          pc[7:0] <= read_data;
          address <= RESET_VECTOR + 16'd1;
        end
        ST_VEC_HI: if (strobe) begin
          pc[15:8] <= read_data;
          address  <= {read_data, pc[7:0]};
        end
        ST_OPCODE: if (strobe) begin
          instr_opcode  <= read_data;
          instr_length  <= new_length;
          instr_pc      <= pc;
          instr_operand <= 16'd0;
          if (new_length != 2'd1) address <= pc + 16'd1;
        end
        ST_OPER_LO: if (strobe) begin
          instr_operand[7:0] <= read_data;
          if (instr_length == 2'd3) address <= address + 16'd1;
        end
        ST_OPER_HI: if (strobe) begin
          instr_operand[15:8] <= read_data;
        end
        ST_HOLD: if (accept) begin
          pc      <= next_pc;
          address <= next_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a program table walked through the
// handshake, plus hand-written reset, redirect, wrap and mid-fetch reset runs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] address;
  logic [7:0]  read_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [1:0]  instr_length;
  logic [15:0] instr_pc;
  logic [2:0]  debug_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_q;
  logic [15:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  // Synchronous memory, one cycle of read latency.
  always @(posedge clk) rd_q <= mem[address];
  assign read_data = rd_q;

  instr_fetch dut (
    .clk            (clk),
    .resetn         (resetn),
    .address        (address),
    .read_data      (read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_operand  (instr_operand),
    .instr_length   (instr_length),
    .instr_pc       (instr_pc),
    .debug_state    (debug_state)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [15:0] pc;
    logic [15:0] operand;
    logic [1:0]  len;
    int          stall;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
  endtask

  // Drive reset low, check the reset values, release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    check({tag, "_rst_address"}, address, 16'hFFFC);
    check({tag, "_rst_valid"}, instr_valid, 1'b0);
    check({tag, "_rst_state"}, debug_state, 3'd0);
    check({tag, "_rst_bundle"}, {instr_opcode, instr_operand, instr_length, instr_pc},
          42'd0);
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, instr_valid, 1'b1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, output int n);
    n = 0;
    while (debug_state !== s && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_state_seen"}, debug_state, s);
  endtask

  task automatic check_bundle(input string tag, input logic [7:0] op, input logic [15:0] oper,
                              input logic [1:0] len, input logic [15:0] pc);
    check({tag, "_opcode"}, instr_opcode, op);
    check({tag, "_operand"}, instr_operand, oper);
    check({tag, "_length"}, instr_length, len);
    check({tag, "_pc"}, instr_pc, pc);
  endtask

  // Accept the held bundle; the next opcode address must follow it.
  task automatic accept(input string tag, input logic [15:0] next_addr);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check({tag, "_valid_drop"}, instr_valid, 1'b0);
    check({tag, "_next_address"}, address, next_addr);
    check({tag, "_next_state"}, debug_state, 3'd2);
  endtask

  initial begin
    int n;
    string tag;

    // program: pc, bytes and expectations worked out by hand
    tbl[0] = '{8'hA9, 8'h42, 8'h00, 16'h8000, 16'h0042, 2'd2, 0};
    tbl[1] = '{8'h4C, 8'h34, 8'h12, 16'h8002, 16'h1234, 2'd3, 5};
    tbl[2] = '{8'hEA, 8'h00, 8'h00, 16'h8005, 16'h0000, 2'd1, 0};
    tbl[3] = '{8'h20, 8'h00, 8'h90, 16'h8006, 16'h9000, 2'd3, 2};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 16'h8009, 16'h0000, 2'd1, 0};
    tbl[5] = '{8'hB9, 8'h78, 8'h56, 16'h800A, 16'h5678, 2'd3, 0};
    tbl[6] = '{8'h09, 8'hFF, 8'h00, 16'h800D, 16'h00FF, 2'd2, 1};
    tbl[7] = '{8'h60, 8'h00, 8'h00, 16'h800F, 16'h0000, 2'd1, 0};
    tbl[8] = '{8'h10, 8'h05, 8'h00, 16'h8010, 16'h0005, 2'd2, 0};

    // ---- reset vector + program table ----
    clear_mem();
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    foreach (tbl[i]) begin
      mem[tbl[i].pc] = tbl[i].b0;
      if (tbl[i].len > 2'd1) mem[tbl[i].pc + 16'd1] = tbl[i].b1;
      if (tbl[i].len > 2'd2) mem[tbl[i].pc + 16'd2] = tbl[i].b2;
    end
    do_reset("vec");
    exp_q.push_back(16'hFFFC);
    exp_q.push_back(16'hFFFD);
    exp_q.push_back(16'hFFFD);
    exp_q.push_back(16'h8000);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("vec_trace_edge%0d", e), address, exp_q.pop_front());
    end

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("rec%0d", i);
      wait_valid(tag, n);
      check({tag, "_latency"}, n, 2 * int'(tbl[i].len));
      check_bundle(tag, tbl[i].b0, tbl[i].operand, tbl[i].len, tbl[i].pc);
      for (int s = 0; s < tbl[i].stall; s++) begin
        tick();
        check($sformatf("%s_stall%0d_valid", tag, s), instr_valid, 1'b1);
        check_bundle($sformatf("%s_stall%0d", tag, s), tbl[i].b0, tbl[i].operand,
                     tbl[i].len, tbl[i].pc);
      end
      accept(tag, tbl[i].pc + 16'(tbl[i].len));
    end

    // ---- redirect (ignored during vector fetch, taken in OPER_LO) ----
    clear_mem();
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'h4C;
    mem[16'h8001] = 8'h34;
    mem[16'h8002] = 8'h12;
    mem[16'hC000] = 8'hEA;
    do_reset("redir");
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    tick();
    redirect_valid = 1'b0;
    wait_state("redir_vec", 3'd2, n);
    check("redir_vec_ignored_address", address, 16'h8000);
    check("redir_vec_cycles", n, 3);
    wait_state("redir_operlo", 3'd3, n);
    redirect_valid = 1'b1;
    redirect_pc = 16'hC000;
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    check("redir_valid_low", instr_valid, 1'b0);
    check("redir_state", debug_state, 3'd2);
    check("redir_address", address, 16'hC000);
    wait_valid("redir_nop", n);
    check("redir_nop_latency", n, 2);
    check_bundle("redir_nop", 8'hEA, 16'h0000, 2'd1, 16'hC000);
    accept("redir_nop", 16'hC001);

    // ---- 16-bit wrap ----
    clear_mem();
    mem[16'hFFFC] = 8'hFF;
    mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFF] = 8'hAD;
    mem[16'h0000] = 8'h10;
    mem[16'h0001] = 8'h20;
    do_reset("wrap");
    wait_valid("wrap", n);
    check_bundle("wrap", 8'hAD, 16'h2010, 2'd3, 16'hFFFF);
    accept("wrap", 16'h0002);

    // ---- asynchronous reset during OPER_HI ----
    clear_mem();
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'h4C;
    mem[16'h8001] = 8'h34;
    mem[16'h8002] = 8'h12;
    do_reset("arst");
    wait_state("arst_operhi", 3'd4, n);
    #2 resetn = 1'b0;
    #1;
    check("arst_async_address", address, 16'hFFFC);
    check("arst_async_valid", instr_valid, 1'b0);
    check("arst_async_state", debug_state, 3'd0);
    @(negedge clk);
    tick();
    resetn = 1'b1;
    wait_state("arst_refetch", 3'd2, n);
    check("arst_refetch_cycles", n, 4);
    check("arst_refetch_address", address, 16'h8000);
    wait_valid("arst_jmp", n);
    check_bundle("arst_jmp", 8'h4C, 16'h1234, 2'd3, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
